// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and BCD helper for the
// ADC averaging / millivolt BCD conversion path.
`timescale 1ns/1ps
package adc_pkg;

  localparam int ADC_WIDTH  = 12;
  localparam int BCD_DIGITS = 4;
  localparam int MV_WIDTH   = 14;
  localparam int MV_MAX     = 9999;
  localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_SCALE = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Add 3 to every digit above 4 ahead of a double-dabble shift
  function automatic logic [BCD_WIDTH-1:0] bcd_add3(
    input logic [BCD_WIDTH-1:0] b
  );
    logic [BCD_WIDTH-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] > 4'd4)
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter, one binary bit per clock.
// o_done marks the cycle doing the final shift; o_bcd is final after it.
`timescale 1ns/1ps
module bin2bcd_seq
  import adc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [MV_WIDTH-1:0]  i_bin,
  output logic                 o_done,
  output logic [BCD_WIDTH-1:0] o_bcd
);

  logic [MV_WIDTH-1:0]  r_bin;
  logic [BCD_WIDTH-1:0] r_bcd;
  logic [3:0]           r_cnt;
  logic                 r_busy;

  logic [BCD_WIDTH-1:0] w_adj;
  logic                 w_last;

  assign w_adj  = bcd_add3(r_bcd);
  assign w_last = r_busy && (r_cnt == 4'(MV_WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= (w_adj << 1) | BCD_WIDTH'(r_bin[MV_WIDTH-1]);
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 4'd1;
      if (w_last)
        r_busy <= 1'b0;
    end
  end

  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/adc_avg_bcd.sv
// Averages 2^AVG_LOG2 ADC samples, scales to millivolts and
// presents the result as 4-digit packed BCD with a valid pulse.
`timescale 1ns/1ps
module adc_avg_bcd
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int VREF_MV  = 3300
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 adc_busy,
  input  logic [2:0]           chan,
  output logic [BCD_WIDTH-1:0] bcd,
  output logic                 bcd_valid,
  output logic                 conv_busy
);

  localparam int ACC_W  = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int PROD_W = ADC_WIDTH + MV_WIDTH;

  state_t r_state, w_next;

  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy_d;
  logic [2:0]           r_chan_d;
  logic                 r_chan_ok;
  logic [BCD_WIDTH-1:0] r_bcd;
  logic                 r_bcd_valid;

  logic                 w_strobe;
  logic                 w_chg;
  logic                 w_last_smp;
  logic [ADC_WIDTH-1:0] w_avg;
  logic [PROD_W-1:0]    w_prod;
  logic [MV_WIDTH-1:0]  w_mv_raw;
  logic [MV_WIDTH-1:0]  w_mv;
  logic                 w_start;
  logic                 w_abort;
  logic                 w_conv_busy;
  logic                 w_done;
  logic [BCD_WIDTH-1:0] w_res;

  assign w_strobe   = r_busy_d & ~adc_busy;
  // chan_d is only meaningful after its first post-reset load
  assign w_chg      = r_chan_ok && (chan != r_chan_d);
  assign w_last_smp = r_cnt == CNT_W'((1 << AVG_LOG2) - 1);

  assign w_avg    = ADC_WIDTH'(r_acc >> AVG_LOG2);
  assign w_prod   = PROD_W'(w_avg) * PROD_W'(VREF_MV);
  assign w_mv_raw = MV_WIDTH'(w_prod >> ADC_WIDTH);
  assign w_mv     = (w_mv_raw > MV_WIDTH'(MV_MAX)) ?
                    MV_WIDTH'(MV_MAX) : w_mv_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_ACC;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACC:
        if (!w_chg && w_strobe && w_last_smp)
          w_next = ST_SCALE;
      ST_SCALE:
        w_next = w_chg ? ST_ACC : ST_CONV;
      ST_CONV:
        if (w_chg)       w_next = ST_ACC;
        else if (w_done) w_next = ST_DONE;
      ST_DONE:
        w_next = ST_ACC;
      default:
        w_next = ST_ACC;
    endcase
  end

  always_comb begin
    w_conv_busy = 1'b0;
    w_start     = 1'b0;
    w_abort     = w_chg;
    case (r_state)
      ST_SCALE: begin
        w_conv_busy = 1'b1;
        w_start     = !w_chg;
      end
      ST_CONV:  w_conv_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_busy_d    <= 1'b0;
      r_chan_d    <= '0;
      r_chan_ok   <= 1'b0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_busy_d    <= adc_busy;
      r_chan_d    <= chan;
      r_chan_ok   <= 1'b1;
      r_bcd_valid <= (r_state == ST_DONE) && !w_chg;
      if ((r_state == ST_DONE) && !w_chg)
        r_bcd <= w_res;
      if (w_chg) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == ST_SCALE) begin
        r_acc <= '0;
      end else if ((r_state == ST_ACC) && w_strobe) begin
        r_acc <= r_acc + ACC_W'(adc_data);
        r_cnt <= w_last_smp ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  bin2bcd_seq u_b2b (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_abort (w_abort),
    .i_bin   (w_mv),
    .o_done  (w_done),
    .o_bcd   (w_res)
  );

  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;
  assign conv_busy = w_conv_busy;

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Randomized self-checking bench for adc_avg_bcd against a
// plain-arithmetic millivolt/BCD reference model.
`timescale 1ns/1ps
module tb_adc_avg_bcd;

  logic        clk;
  logic        rst;
  logic [11:0] adc_data;
  logic        adc_busy;
  logic [2:0]  chan;
  logic [15:0] bcd, bcd0;
  logic        bcd_valid, bcd_valid0;
  logic        conv_busy, conv_busy0;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  logic [15:0] last_exp = 16'h0000;

  adc_avg_bcd #(.AVG_LOG2(3), .VREF_MV(3300)) u_dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_busy(adc_busy),
    .chan(chan), .bcd(bcd), .bcd_valid(bcd_valid), .conv_busy(conv_busy)
  );

  adc_avg_bcd #(.AVG_LOG2(0), .VREF_MV(5000)) u_dut0 (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_busy(adc_busy),
    .chan(chan), .bcd(bcd0), .bcd_valid(bcd_valid0),
    .conv_busy(conv_busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bcd_valid === 1'b1) vcnt++;

  function automatic logic [15:0] model(input int sum, input int n,
                                        input int vref);
    int avg, mv;
    logic [15:0] r;
    avg = sum / n;
    mv  = (avg * vref) / 4096;
    if (mv > 9999) mv = 9999;
    r[15:12] = 4'(mv / 1000);
    r[11:8]  = 4'((mv / 100) % 10);
    r[7:4]   = 4'((mv / 10) % 10);
    r[3:0]   = 4'(mv % 10);
    return r;
  endfunction

  task automatic send(input logic [11:0] d);
    @(negedge clk) adc_busy = 1'b1;
    @(negedge clk);
    adc_busy = 1'b0;
    adc_data = d;
  endtask

  task automatic finish_check(input bit sel, input logic [15:0] exp,
                              input bit inject, input string nm);
    int vpos = 0;
    int vn = 0;
    int bn = 0;
    logic [15:0] got = 16'hxxxx;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (inject && j == 3) adc_busy = 1'b1;
      if (inject && j == 5) begin
        adc_busy = 1'b0;
        adc_data = 12'($urandom);
      end
      if ((sel ? bcd_valid0 : bcd_valid) === 1'b1) begin
        vn++;
        vpos = j - 1;
        got = sel ? bcd0 : bcd;
      end
      if ((sel ? conv_busy0 : conv_busy) === 1'b1) bn++;
    end
    checks++;
    if (vn !== 1 || vpos !== 16) begin
      failures++;
      $display("FAIL %s valid: pulses=%0d at=%0d, need 1 at 16",
               nm, vn, vpos);
    end
    checks++;
    if (bn !== 15) begin
      failures++;
      $display("FAIL %s conv_busy: cycles=%0d, need 15", nm, bn);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s bcd: got=%h need=%h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bcd !== 16'h0 || bcd_valid !== 1'b0 || conv_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_main: bcd=%h v=%b b=%b need 0000 0 0",
               bcd, bcd_valid, conv_busy);
    end
    checks++;
    if (bcd0 !== 16'h0 || bcd_valid0 !== 1'b0 || conv_busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0: bcd=%h v=%b b=%b need 0000 0 0",
               bcd0, bcd_valid0, conv_busy0);
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_scale();
    repeat (8) send(12'd4095);
    last_exp = model(8 * 4095, 8, 3300);
    finish_check(0, 16'h3299, 0, "full_scale");
  endtask

  task automatic test_mid_zero();
    repeat (8) send(12'd2048);
    finish_check(0, 16'h1650, 0, "mid");
    repeat (8) send(12'd0);
    last_exp = 16'h0000;
    finish_check(0, 16'h0000, 0, "zero");
  endtask

  task automatic test_alt_inject();
    int v0;
    for (int i = 0; i < 8; i++) send(i[0] ? 12'd1008 : 12'd1000);
    finish_check(0, 16'h0808, 0, "alt");
    for (int i = 0; i < 8; i++) send(i[0] ? 12'd1008 : 12'd1000);
    finish_check(0, 16'h0808, 1, "alt_inject");
    repeat (7) send(12'd2048);
    v0 = vcnt;
    repeat (20) @(negedge clk);
    checks++;
    if (vcnt !== v0) begin
      failures++;
      $display("FAIL discard_count: pulses=%0d need 0", vcnt - v0);
    end
    send(12'd2048);
    last_exp = 16'h1650;
    finish_check(0, 16'h1650, 0, "fresh_eight");
  endtask

  task automatic test_chan_change();
    int v0;
    repeat (5) send(12'd4095);
    @(negedge clk) chan = 3'd3;
    repeat (3) @(negedge clk);
    v0 = vcnt;
    repeat (7) send(12'd1024);
    repeat (20) @(negedge clk);
    checks++;
    if (vcnt !== v0) begin
      failures++;
      $display("FAIL chg_novalid: pulses=%0d need 0", vcnt - v0);
    end
    checks++;
    if (bcd !== last_exp) begin
      failures++;
      $display("FAIL chg_hold: bcd=%h need=%h", bcd, last_exp);
    end
    send(12'd1024);
    last_exp = 16'h0825;
    finish_check(0, 16'h0825, 0, "chan_change");
  endtask

  task automatic test_reset_mid();
    repeat (8) send(12'd4095);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bcd !== 16'h0 || bcd_valid !== 1'b0 || conv_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: bcd=%h v=%b b=%b need 0000 0 0",
               bcd, bcd_valid, conv_busy);
    end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    repeat (8) send(12'd2048);
    last_exp = 16'h1650;
    finish_check(0, 16'h1650, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int sum = 0;
      for (int i = 0; i < 8; i++) begin
        logic [11:0] d;
        d = 12'($urandom_range(0, 4095));
        sum += int'(d);
        send(d);
      end
      last_exp = model(sum, 8, 3300);
      finish_check(0, last_exp, 0, "random_avg");
    end
  endtask

  task automatic test_single();
    send(12'd4095);
    finish_check(1, 16'h4998, 0, "single_5000");
    for (int r = 0; r < 3; r++) begin
      logic [11:0] d;
      d = 12'($urandom_range(0, 4095));
      send(d);
      finish_check(1, model(int'(d), 1, 5000), 0, "single_rand");
    end
  endtask

  initial begin
    rst      = 1'b0;
    adc_busy = 1'b0;
    adc_data = 12'd0;
    chan     = 3'd0;
    test_reset();
    test_full_scale();
    test_mid_zero();
    test_alt_inject();
    test_chan_change();
    test_reset_mid();
    test_random();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
